// File: rtl/hack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hack_pkg                                                 |
// | Description : Shared constants and fetch-state encoding for the Hack   |
// |               CPU program-counter / instruction-fetch stage.           |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package hack_pkg;

    localparam int HACK_AW  = 15;   // instruction address / PC width
    localparam int HACK_DW  = 16;   // instruction width
    localparam int PC_RESET = 0;    // program counter value after reset

    // HALT is only entered when HACK_FETCH_HALT_EN is defined.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage : hack_pkg
`default_nettype wire

// File: rtl/hack_pc_reg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hack_pc_reg                                              |
// | Description : AW-bit program counter register. Synchronous reset to    |
// |               PC_RESET, parallel load of d, or increment (mod 2^AW).   |
// |               load has priority over inc.                              |
// | Ports       : clk, rst   - clock, synchronous active-high reset        |
// |               load, d    - load d into the counter                     |
// |               inc        - increment the counter                       |
// |               q          - current counter value                       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module hack_pc_reg
    import hack_pkg::*;
#(
    parameter int AW = HACK_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);

    logic [AW-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= AW'(PC_RESET);
        end else if (load) begin
            r_pc <= d;
        end else if (inc) begin
            r_pc <= r_pc + AW'(1);   // natural wrap at 2^AW
        end
    end

    assign q = r_pc;

endmodule : hack_pc_reg
`default_nettype wire

// File: rtl/hack_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : hack_fetch                                               |
// | Description : Hack CPU program counter and instruction fetch stage.    |
// |               Moore FSM FETCH -> WAIT -> EXEC. Requests the word at pc |
// |               over a req/ready + rvalid handshake, presents it to the  |
// |               execute stage until exec_done, then advances or jumps.   |
// | Ports       : clk, rst            - clock, synchronous active-high rst |
// |               load_pc, jump_addr  - jump decision / target (EXEC only) |
// |               exec_done           - execute stage completion pulse     |
// |               imem_req/addr       - fetch request, address = pc        |
// |               imem_ready          - memory accepts request             |
// |               imem_rvalid/rdata   - read response                      |
// |               instr, instr_valid  - instruction to execute stage       |
// |               pc                  - current program counter            |
// |               halted              - (HACK_FETCH_HALT_EN only) sticky   |
// |                                     self-loop halt indication          |
// | Options     : HACK_FETCH_HALT_EN  - enable HALT state and halted port  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module hack_fetch
    import hack_pkg::*;
#(
    parameter int AW = HACK_AW,
    parameter int DW = HACK_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_pc,
    input  logic [AW-1:0] jump_addr,
    input  logic          exec_done,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
`ifdef HACK_FETCH_HALT_EN
    output logic          halted,
`endif
    output logic [AW-1:0] pc
);

    fetch_state_t  r_state;
    logic          r_req;
    logic [DW-1:0] r_instr;
    logic          r_valid;
    logic [AW-1:0] w_pc;
    logic          w_fire;
    logic          w_self_jump;
    logic          w_load;
    logic          w_inc;

    // Execute stage retires the current instruction this cycle.
    assign w_fire = (r_state == EXEC) && exec_done;

`ifdef HACK_FETCH_HALT_EN
    logic r_halted;
    assign w_self_jump = load_pc && (jump_addr == w_pc);
    assign halted      = r_halted;
`else
    assign w_self_jump = 1'b0;
`endif

    // A self-jump in the halt build leaves pc untouched, so the load is
    // suppressed; the value would be identical anyway.
    assign w_load = w_fire && load_pc && !w_self_jump;
    assign w_inc  = w_fire && !load_pc;

    hack_pc_reg #(
        .AW   (AW)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .inc  (w_inc),
        .d    (jump_addr),
        .q    (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_req    <= 1'b0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
`ifdef HACK_FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else begin
            case (r_state)
                FETCH: begin
                    // r_req is low only in the first cycle after reset, so
                    // a ready seen then is not an acceptance.
                    if (r_req && imem_ready) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (w_self_jump) begin
`ifdef HACK_FETCH_HALT_EN
                            r_halted <= 1'b1;
                            r_state  <= HALT;
`endif
                        end else begin
                            r_valid <= 1'b0;
                            r_req   <= 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
`ifdef HACK_FETCH_HALT_EN
                HALT: begin
                    r_state <= HALT;   // only rst leaves HALT
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_req   <= 1'b1;
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = w_pc;
    assign pc          = w_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;

endmodule : hack_fetch
`default_nettype wire

// File: tb/tb_hack_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_hack_fetch                                            |
// | Description : Self-checking bench for hack_fetch. A table of fetch /   |
// |               execute transactions drives the block; expected words   |
// |               are queued at request acceptance and popped when         |
// |               instr_valid rises. Hand sequences cover reset in WAIT,   |
// |               the self-jump (halt or refetch) and rst over exec_done.  |
// | Options     : HACK_FETCH_HALT_EN  - bench follows the halt build       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_hack_fetch;
    localparam int AW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_pc;
    logic [AW-1:0] jump_addr;
    logic          exec_done;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
`ifdef HACK_FETCH_HALT_EN
    logic          halted;
`endif

    hack_fetch #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_pc     (load_pc),
        .jump_addr   (jump_addr),
        .exec_done   (exec_done),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
`ifdef HACK_FETCH_HALT_EN
        .halted      (halted),
`endif
        .pc          (pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        logic          ld;
        logic [AW-1:0] ja;
        int            rdly;    // cycles of imem_ready=0 before acceptance
        int            vdly;    // extra WAIT cycles before rvalid
        int            edly;    // EXEC cycles before exec_done
        logic [AW-1:0] exp_pc;  // pc after exec_done
    } vec_t;

    vec_t vecs[7];

    // Instruction memory contents as seen by the bench.
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == '0) return 16'h0010;
        return {a, 1'b1} ^ 16'h5A00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic fetch_one(input int rdly, input int vdly, input logic [AW-1:0] exp_addr);
        int n;
        logic [DW-1:0] held;
        logic [DW-1:0] exp_w;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            chk("req_timeout", 32'(imem_req), 32'(1));
            return;
        end
        chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        chk("fetch_valid_low", 32'(instr_valid), 32'(0));
        held = instr;
        for (int i = 0; i < rdly; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = (i == 1);
            imem_rdata  = 16'hDEAD;
            step();
            chk("bp_req", 32'(imem_req), 32'(1));
            chk("bp_addr", 32'(imem_addr), 32'(exp_addr));
            chk("stray_rvalid_instr", 32'(instr), 32'(held));
        end
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        sb.push_back(mem(exp_addr));
        step();
        imem_ready = 1'b0;
        chk("req_drop", 32'(imem_req), 32'(0));
        for (int i = 0; i < vdly; i++) begin
            exec_done = 1'b1;   // must be ignored in WAIT
            load_pc   = 1'b1;
            jump_addr = 15'h1234;
            step();
            exec_done = 1'b0;
            load_pc   = 1'b0;
            chk("wait_req", 32'(imem_req), 32'(0));
            chk("wait_valid", 32'(instr_valid), 32'(0));
            chk("wait_pc", 32'(pc), 32'(exp_addr));
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem(exp_addr);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 16'hFFFF;
        chk("instr_valid", 32'(instr_valid), 32'(1));
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(0), 32'(1));
        end else begin
            exp_w = sb.pop_front();
            chk("instr", 32'(instr), 32'(exp_w));
        end
    endtask

    task automatic exec_one(input int edly, input logic ld, input logic [AW-1:0] ja,
                            input logic [AW-1:0] exp_pc);
        logic [DW-1:0] held;
        held = instr;
        for (int i = 0; i < edly; i++) begin
            load_pc     = 1'b1;          // don't-care without exec_done
            jump_addr   = 15'h2AAA;
            imem_rvalid = 1'b1;          // ignored outside WAIT
            imem_rdata  = 16'hBEEF;
            step();
            imem_rvalid = 1'b0;
            chk("exec_valid", 32'(instr_valid), 32'(1));
            chk("exec_req", 32'(imem_req), 32'(0));
            chk("exec_instr_hold", 32'(instr), 32'(held));
        end
        exec_done = 1'b1;
        load_pc   = ld;
        jump_addr = ja;
        step();
        exec_done = 1'b0;
        load_pc   = 1'b0;
        jump_addr = '0;
        chk("next_pc", 32'(pc), 32'(exp_pc));
        chk("retire_valid", 32'(instr_valid), 32'(0));
        chk("refetch_req", 32'(imem_req), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 15'h0005, 0, 0, 0, 15'h0005};
        vecs[1] = '{1'b0, 15'h0000, 0, 0, 1, 15'h0006};
        vecs[2] = '{1'b1, 15'h0100, 0, 1, 0, 15'h0100};
        vecs[3] = '{1'b1, 15'h7FFF, 1, 0, 2, 15'h7FFF};
        vecs[4] = '{1'b0, 15'h0000, 0, 0, 0, 15'h0000};
        vecs[5] = '{1'b0, 15'h0000, 4, 2, 1, 15'h0001};
        vecs[6] = '{1'b1, 15'h0007, 0, 0, 0, 15'h0007};

        rst = 1'b1; load_pc = 1'b0; jump_addr = '0; exec_done = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (3) step();
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_instr", 32'(instr), 32'(0));
        chk("rst_valid", 32'(instr_valid), 32'(0));
        chk("rst_req", 32'(imem_req), 32'(0));
`ifdef HACK_FETCH_HALT_EN
        chk("rst_halted", 32'(halted), 32'(0));
`endif
        rst = 1'b0;
        step();
        chk("first_req", 32'(imem_req), 32'(1));
        chk("first_addr", 32'(imem_addr), 32'(0));

        begin
            logic [AW-1:0] model_pc;
            model_pc = '0;
            for (int v = 0; v < 7; v++) begin
                fetch_one(vecs[v].rdly, vecs[v].vdly, model_pc);
                exec_one(vecs[v].edly, vecs[v].ld, vecs[v].ja, vecs[v].exp_pc);
                model_pc = vecs[v].exp_pc;
            end
        end

        // Reset in WAIT with a response arriving in the same cycle.
        chk("pre_rst_addr", 32'(imem_addr), 32'(7));
        imem_ready = 1'b1;
        step();
        imem_ready  = 1'b0;
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBEEF;
        step();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        chk("wrst_instr", 32'(instr), 32'(0));
        chk("wrst_valid", 32'(instr_valid), 32'(0));
        chk("wrst_pc", 32'(pc), 32'(0));
        chk("wrst_req", 32'(imem_req), 32'(0));
        step();
        chk("wrst_refetch_req", 32'(imem_req), 32'(1));
        chk("wrst_refetch_addr", 32'(imem_addr), 32'(0));
        fetch_one(0, 0, 15'h0000);
        exec_one(0, 1'b1, 15'h0007, 15'h0007);
        fetch_one(0, 0, 15'h0007);

        // Self-jump at pc=7.
        begin
            logic [DW-1:0] held;
            held = instr;
            exec_done = 1'b1;
            load_pc   = 1'b1;
            jump_addr = 15'h0007;
            step();
            exec_done = 1'b0;
            load_pc   = 1'b0;
            chk("self_pc", 32'(pc), 32'(7));
`ifdef HACK_FETCH_HALT_EN
            chk("halted_set", 32'(halted), 32'(1));
            for (int i = 0; i < 10; i++) begin
                imem_ready = 1'b1;
                exec_done  = (i % 3 == 0);
                step();
                chk("halt_req", 32'(imem_req), 32'(0));
                chk("halt_instr", 32'(instr), 32'(held));
                chk("halt_valid", 32'(instr_valid), 32'(1));
                chk("halt_sticky", 32'(halted), 32'(1));
            end
            imem_ready = 1'b0;
            exec_done  = 1'b0;
            chk("halt_pc", 32'(pc), 32'(7));
`else
            chk("self_refetch_req", 32'(imem_req), 32'(1));
            fetch_one(0, 0, 15'h0007);
`endif
        end

        // rst together with exec_done: reset wins.
        rst       = 1'b1;
        exec_done = 1'b1;
        load_pc   = 1'b1;
        jump_addr = 15'h0123;
        step();
        rst = 1'b0; exec_done = 1'b0; load_pc = 1'b0;
        chk("rst_exec_pc", 32'(pc), 32'(0));
        chk("rst_exec_valid", 32'(instr_valid), 32'(0));
`ifdef HACK_FETCH_HALT_EN
        chk("rst_clears_halted", 32'(halted), 32'(0));
`endif
        step();
        chk("rst_exec_req", 32'(imem_req), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_hack_fetch
`default_nettype wire
